// File: rtl/div_ctrl.sv
// div_ctrl: issues one divider start per divide instruction, stalls EX while it runs and holds the result.
// Build option DIV_CTRL_REUSE_EN answers a repeat of the last completed divide without restarting the divider.
module div_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_signed,
    input  logic             req_is_mod,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             div_start,
    output logic             div_signed,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             pause_div,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             div_err
);

    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic             signed_q;
    logic             is_mod_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;

    logic             watchdog;
    logic             capture;
    logic             reuse_load;
    logic             reuse_hit;
    logic [WIDTH-1:0] reuse_value;

    // The counter keeps running through DRAIN so a divider that never answers cannot park us there.
    assign watchdog = (cnt_q >= CNT_LIMIT);
    assign result   = result_q;

`ifdef DIV_CTRL_REUSE_EN
    logic             reuse_valid;
    logic             reuse_signed;
    logic [WIDTH-1:0] reuse_dividend;
    logic [WIDTH-1:0] reuse_divisor;
    logic [WIDTH-1:0] reuse_quotient;
    logic [WIDTH-1:0] reuse_remainder;

    assign reuse_hit   = reuse_valid && (reuse_signed == req_signed) &&
                         (reuse_dividend == req_dividend) && (reuse_divisor == req_divisor);
    assign reuse_value = req_is_mod ? reuse_remainder : reuse_quotient;

    always_ff @(posedge clk) begin
        if (rst) begin
            reuse_valid     <= 1'b0;
            reuse_signed    <= 1'b0;
            reuse_dividend  <= '0;
            reuse_divisor   <= '0;
            reuse_quotient  <= '0;
            reuse_remainder <= '0;
        end else if (capture) begin
            reuse_valid     <= 1'b1;
            reuse_signed    <= signed_q;
            reuse_dividend  <= dividend_q;
            reuse_divisor   <= divisor_q;
            reuse_quotient  <= div_quotient;
            reuse_remainder <= div_remainder;
        end
    end
`else
    assign reuse_hit   = 1'b0;
    assign reuse_value = '0;
`endif

    always_comb begin
        // NOTE: every output and next-state gets a default first, so no path can infer a latch.
        state_next   = state;
        div_start    = 1'b0;
        div_signed   = signed_q;
        div_dividend = dividend_q;
        div_divisor  = divisor_q;
        pause_div    = 1'b0;
        result_valid = 1'b0;
        div_err      = 1'b0;
        capture      = 1'b0;
        reuse_load   = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    pause_div = 1'b1;
                    if (reuse_hit) begin
                        reuse_load = 1'b1;
                        state_next = DONE;
                    end else begin
                        div_start    = 1'b1;
                        div_signed   = req_signed;
                        div_dividend = req_dividend;
                        div_divisor  = req_divisor;
                        state_next   = RUN;
                    end
                end
            end
            RUN: begin
                pause_div = 1'b1;
                if (div_done) begin
                    if (flush) begin
                        state_next = IDLE;
                    end else begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                end else if (watchdog) begin
                    div_err    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (!ex_stall || flush) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                // A waiting divide is stalled here but never started until the stale result is gone.
                pause_div = req_valid && !flush;
                if (div_done || watchdog) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            signed_q   <= 1'b0;
            is_mod_q   <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state <= state_next;
            if (div_start) begin
                signed_q   <= req_signed;
                is_mod_q   <= req_is_mod;
                dividend_q <= req_dividend;
                divisor_q  <= req_divisor;
                cnt_q      <= '0;
            end else if (state == RUN || state == DRAIN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture) begin
                result_q <= is_mod_q ? div_remainder : div_quotient;
            end else if (reuse_load) begin
                result_q <= reuse_value;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and randomized divide requests against a transaction-level model of div_ctrl,
// with a latency-programmable divider model driving div_done.
module tb_div_ctrl;

    localparam int W    = 32;
    localparam int MAXC = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_signed, req_is_mod;
    logic [W-1:0] req_dividend, req_divisor;
    logic         ex_stall, flush;
    logic         div_start, div_signed;
    logic [W-1:0] div_dividend, div_divisor;
    logic         div_done;
    logic [W-1:0] div_quotient, div_remainder;
    logic         pause_div, result_valid, div_err;
    logic [W-1:0] result;

    div_ctrl #(.WIDTH(W), .MAX_CYCLES(MAXC)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_signed   (req_signed),
        .req_is_mod   (req_is_mod),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .pause_div    (pause_div),
        .result_valid (result_valid),
        .result       (result),
        .div_err      (div_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void divcalc(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == '1) begin
            q = a;
            r = '0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Divider model: answers dv_lat cycles after the start cycle, or never when dv_dead is set.
    int           kick_req = 0;
    int           kick_ack = 0;
    bit           dv_busy = 0;
    bit           dv_dead = 0;
    int           dv_cnt = 0;
    int           dv_lat = 33;
    int           dv_cur_lat = 33;
    logic [W-1:0] dv_q, dv_r;

    always @(posedge clk) begin
        #1;
        div_done      = 1'b0;
        div_quotient  = $urandom;
        div_remainder = $urandom;
        if (kick_req != kick_ack) begin
            kick_ack   = kick_req;
            dv_busy    = 1;
            dv_cnt     = 1;
            dv_cur_lat = dv_lat;
        end else if (dv_busy) begin
            dv_cnt++;
        end
        if (dv_busy && !dv_dead && dv_cnt >= dv_cur_lat) begin
            div_done      = 1'b1;
            div_quotient  = dv_q;
            div_remainder = dv_r;
            dv_busy       = 0;
        end
    end

    // Reference model: tracks the instruction's divide as transaction flags rather than controller states.
    bit           mon_en = 0;
    bit           m_ready = 0;      // a result is held for EX
    bit           m_out = 0;        // our divide is outstanding in the divider
    bit           m_live = 0;       // the outstanding divide still belongs to a live instruction
    int           m_age = 0;        // cycles the outstanding divide has been running
    logic [W-1:0] m_res = '0;
    logic         m_op_sgn, m_op_mod;
    logic [W-1:0] m_op_a, m_op_b;
    bit           m_last_v = 0;
    logic         m_last_sgn;
    logic [W-1:0] m_last_a, m_last_b, m_last_q, m_last_r;
    int           n_start = 0, n_pause = 0, n_err = 0;
    bit           e_start, e_pause, e_valid, e_err, e_hit;

    always @(negedge clk) begin
        if (mon_en) begin
            e_start = 0; e_pause = 0; e_valid = 0; e_err = 0; e_hit = 0;
            if (m_ready) begin
                e_valid = 1;
            end else if (m_out && m_live) begin
                e_pause = 1;
                e_err   = !div_done && !flush && (m_age == MAXC - 1);
                check("run_signed", div_signed, m_op_sgn);
                check("run_dividend", div_dividend, m_op_a);
                check("run_divisor", div_divisor, m_op_b);
            end else if (m_out) begin
                e_pause = req_valid && !flush;
            end else if (req_valid && !flush) begin
                e_pause = 1;
`ifdef DIV_CTRL_REUSE_EN
                e_hit = m_last_v && m_last_sgn == req_signed &&
                        m_last_a == req_dividend && m_last_b == req_divisor;
`endif
                if (!e_hit) begin
                    e_start = 1;
                    check("start_signed", div_signed, req_signed);
                    check("start_dividend", div_dividend, req_dividend);
                    check("start_divisor", div_divisor, req_divisor);
                end
            end
            check("div_start", div_start, e_start);
            check("pause_div", pause_div, e_pause);
            check("result_valid", result_valid, e_valid);
            check("div_err", div_err, e_err);
            if (e_valid) check("result", result, m_res);

            if (div_start) begin
                n_start++;
                divcalc(div_signed, div_dividend, div_divisor, dv_q, dv_r);
                kick_req++;
            end
            if (pause_div) n_pause++;
            if (div_err) n_err++;

            if (m_ready) begin
                if (!ex_stall || flush) m_ready = 0;
            end else if (m_out && m_live) begin
                if (div_done) begin
                    m_out = 0;
                    if (!flush) begin
                        m_ready    = 1;
                        m_res      = m_op_mod ? div_remainder : div_quotient;
                        m_last_v   = 1;
                        m_last_sgn = m_op_sgn;
                        m_last_a   = m_op_a;
                        m_last_b   = m_op_b;
                        m_last_q   = div_quotient;
                        m_last_r   = div_remainder;
                    end
                end else begin
                    m_age++;
                    if (flush || e_err) m_live = 0;
                end
            end else if (m_out) begin
                if (div_done || m_age >= MAXC - 1) m_out = 0;
                else m_age++;
            end else if (req_valid && !flush) begin
                if (e_hit) begin
                    m_ready = 1;
                    m_res   = req_is_mod ? m_last_r : m_last_q;
                end else begin
                    m_out    = 1;
                    m_live   = 1;
                    m_age    = 0;
                    m_op_sgn = req_signed;
                    m_op_mod = req_is_mod;
                    m_op_a   = req_dividend;
                    m_op_b   = req_divisor;
                end
            end
        end
    end

    // Presents one instruction in EX (called just after a rising edge) until it retires, is flushed or errors.
    task automatic run_op(input logic sgn, input logic mod, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall_n, input int flush_at,
                          output logic [W-1:0] res, output bit got, output int lat,
                          output int err_at, output int done_cycles, output bit held);
        bit           fin;
        int           stalled;
        logic [W-1:0] first;
        fin = 0; got = 0; lat = -1; err_at = -1; done_cycles = 0; held = 1; stalled = 0;
        res = '0; first = '0;
        req_valid = 1; req_signed = sgn; req_is_mod = mod; req_dividend = a; req_divisor = b;
        ex_stall = (stall_n > 0);
        for (int c = 0; c < 300 && !fin; c++) begin
            flush = (c == flush_at);
            @(negedge clk);
            if (flush) begin
                fin = 1;
            end else if (div_err) begin
                err_at = c;
                fin    = 1;
            end else if (result_valid) begin
                if (done_cycles == 0) begin
                    lat   = c;
                    first = result;
                end else if (result !== first) begin
                    held = 0;
                end
                done_cycles++;
                res = result;
                if (!ex_stall) begin
                    got = 1;
                    fin = 1;
                end else begin
                    stalled++;
                end
            end
            @(posedge clk); #2;
            if (stalled >= stall_n) ex_stall = 0;
        end
        check("op_timeout", fin, 1);
        req_valid = 0; flush = 0; ex_stall = 0;
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    logic [W-1:0] res, ra, rb, pa, pb;
    bit           got, held;
    int           lat, err_at, dcyc, s0, p0, e0;

    initial begin
        rst = 1; req_valid = 0; req_signed = 0; req_is_mod = 0;
        req_dividend = '0; req_divisor = '0; ex_stall = 0; flush = 0;
        div_done = 0; div_quotient = '0; div_remainder = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 0;
        mon_en = 1;

        @(negedge clk);
        check("rst_div_start", div_start, 0);
        check("rst_pause", pause_div, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_div_err", div_err, 0);
        check("rst_div_signed", div_signed, 0);
        check("rst_div_dividend", div_dividend, 0);
        check("rst_div_divisor", div_divisor, 0);
        tick();

        // Unsigned 100/7 with a 33-cycle divider.
        dv_lat = 33; s0 = n_start; p0 = n_pause;
        run_op(0, 0, 32'd100, 32'd7, 0, -1, res, got, lat, err_at, dcyc, held);
        check("divu_result", res, 14);
        check("divu_got", got, 1);
        check("divu_latency", lat, 34);
        check("divu_starts", n_start - s0, 1);
        check("divu_pause_cycles", n_pause - p0, 34);
        repeat (3) tick();
        run_op(0, 1, 32'd100, 32'd7, 0, -1, res, got, lat, err_at, dcyc, held);
        check("modu_result", res, 2);

        // Signed -7/2.
        run_op(1, 0, 32'hFFFF_FFF9, 32'd2, 0, -1, res, got, lat, err_at, dcyc, held);
        check("divs_result", res, 32'hFFFF_FFFD);
        run_op(1, 1, 32'hFFFF_FFF9, 32'd2, 0, -1, res, got, lat, err_at, dcyc, held);
        check("mods_result", res, 32'hFFFF_FFFF);

        // EX stalls five cycles while the result is held.
        s0 = n_start;
        run_op(0, 0, 32'd1000, 32'd3, 5, -1, res, got, lat, err_at, dcyc, held);
        check("stall_result", res, 333);
        check("stall_done_cycles", dcyc, 6);
        check("stall_held", held, 1);
        check("stall_starts", n_start - s0, 1);
        @(negedge clk);
        check("stall_idle_after", result_valid, 0);
        tick();

        // Flush at RUN cycle 10, next divide presented two cycles later.
        s0 = n_start;
        run_op(0, 0, 32'd200, 32'd9, 0, 10, res, got, lat, err_at, dcyc, held);
        check("flush_no_result", got, 0);
        tick();
        run_op(0, 0, 32'd50, 32'd5, 0, -1, res, got, lat, err_at, dcyc, held);
        check("after_flush_result", res, 10);
        check("after_flush_latency", lat, 56);
        check("after_flush_starts", n_start - s0, 2);

        // Flush in the request cycle never starts the divider.
        s0 = n_start;
        run_op(0, 0, 32'd81, 32'd9, 0, 0, res, got, lat, err_at, dcyc, held);
        check("flush_idle_starts", n_start - s0, 0);
        tick();

        // Divider never answers: watchdog.
        dv_dead = 1; e0 = n_err;
        run_op(0, 0, 32'd77, 32'd3, 0, -1, res, got, lat, err_at, dcyc, held);
        check("wd_err_cycle", err_at, 40);
        check("wd_err_pulses", n_err - e0, 1);
        check("wd_no_result", dcyc, 0);
        dv_dead = 0;
        tick();
        run_op(1, 1, 32'hFFFF_FFEF, 32'd5, 0, -1, res, got, lat, err_at, dcyc, held);
        check("wd_recover_result", res, 32'hFFFF_FFFE);
        check("wd_recover_latency", lat, 34);

        // Repeat of the last completed divide.
        run_op(1, 0, 32'd100, 32'd7, 0, -1, res, got, lat, err_at, dcyc, held);
        check("reuse_first_result", res, 14);
        check("reuse_first_latency", lat, 34);
        s0 = n_start;
        run_op(1, 1, 32'd100, 32'd7, 0, -1, res, got, lat, err_at, dcyc, held);
        check("reuse_second_result", res, 2);
`ifdef DIV_CTRL_REUSE_EN
        check("reuse_second_latency", lat, 1);
        check("reuse_second_starts", n_start - s0, 0);
`else
        check("reuse_second_latency", lat, 34);
        check("reuse_second_starts", n_start - s0, 1);
`endif

        // Randomized instruction stream checked cycle by cycle by the model.
        pa = 32'd100; pb = 32'd7;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 20); end
                1: begin ra = $urandom; rb = $urandom; end
                2: begin ra = $urandom; rb = '0; end
                3: begin ra = 32'h8000_0000; rb = '1; end
                default: begin ra = 0 - $urandom_range(1, 500); rb = $urandom_range(1, 30); end
            endcase
            if ($urandom_range(0, 3) == 0) begin ra = pa; rb = pb; end
            pa = ra; pb = rb;
            dv_lat = ($urandom_range(0, 7) == 0) ? 44 : $urandom_range(1, 38);
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb,
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? $urandom_range(0, 45) : -1,
                   res, got, lat, err_at, dcyc, held);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (50) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
